vga_frame_mux: RTL and testbench

- N-channel VGA source selector for the display path.
- Switches between video sources only on frame boundaries, so the monitor never sees a torn frame or a broken sync train.
- Blanks the colour outputs for a programmable number of frames after each switch.
- Output is registered. Sits between the per-mode VGA generators and the board VGA pins.

---
 rtl/vga_frame_mux.sv | 185 ++++++++++++++++++
 tb/tb_vga_frame_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_mux.sv
// Frame-synchronous VGA source selector with post-switch colour blanking and dead-source timeout.
// Optional macro VGA_FRAME_MUX_BLANK_COLOR_EN: blank with blank_color_i instead of black.
module vga_frame_mux #(
  parameter int CH_CNT       = 4,
  parameter int SEL_W        = $clog2(CH_CNT),
  parameter int COLOR_W      = 4,
  parameter bit VS_POL       = 1'b0,
  parameter int BLANK_FRAMES = 2,
  parameter int TIMEOUT_CYC  = 2000000,
  parameter int TMO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic [CH_CNT-1:0]         hs_i,
  input  logic [CH_CNT-1:0]         vs_i,
  input  logic [CH_CNT*COLOR_W-1:0] red_i,
  input  logic [CH_CNT*COLOR_W-1:0] green_i,
  input  logic [CH_CNT*COLOR_W-1:0] blue_i,
  input  logic [3*COLOR_W-1:0]      blank_color_i,
  output logic                      hs_o,
  output logic                      vs_o,
  output logic [COLOR_W-1:0]        red_o,
  output logic [COLOR_W-1:0]        green_o,
  output logic [COLOR_W-1:0]        blue_o,
  output logic [SEL_W-1:0]          cur_ch_o,
  output logic                      busy_o,
  output logic                      sel_err_o
);

  localparam int IDX_W = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;
  localparam int FR_W  = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'((BLANK_FRAMES > 0) ? (BLANK_FRAMES - 1) : 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CH_CNT);
  localparam logic             VS_INACT = ~VS_POL;

  typedef enum logic [1:0] {
    ST_LOCK    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_BLANK   = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [SEL_W-1:0]    req_ch_r;
  logic [SEL_W-1:0]    cur_ch_r, cur_ch_nxt_s;
  logic [FR_W-1:0]     frame_cnt_r, frame_cnt_nxt_s;
  logic [TMO_W-1:0]    tmo_cnt_r, tmo_cnt_nxt_s;
  logic [CH_CNT-1:0]   vs_dly_r;
  logic [IDX_W-1:0]    cur_idx_s;
  logic                sel_valid_s;
  logic                vs_edge_s;
  logic                tmo_hit_s;
  logic [COLOR_W-1:0]  blank_r_s, blank_g_s, blank_b_s;

  logic [COLOR_W-1:0]  red_a   [CH_CNT];
  logic [COLOR_W-1:0]  green_a [CH_CNT];
  logic [COLOR_W-1:0]  blue_a  [CH_CNT];

  genvar k;
  for (k = 0; k < CH_CNT; k++) begin : g_unpack
    assign red_a[k]   = red_i[k*COLOR_W +: COLOR_W];
    assign green_a[k] = green_i[k*COLOR_W +: COLOR_W];
    assign blue_a[k]  = blue_i[k*COLOR_W +: COLOR_W];
  end

`ifdef VGA_FRAME_MUX_BLANK_COLOR_EN
  assign blank_r_s = blank_color_i[3*COLOR_W-1 -: COLOR_W];
  assign blank_g_s = blank_color_i[2*COLOR_W-1 -: COLOR_W];
  assign blank_b_s = blank_color_i[COLOR_W-1:0];
`else
  logic unused_blank_s;
  assign unused_blank_s = ^blank_color_i;
  assign blank_r_s = '0;
  assign blank_g_s = '0;
  assign blank_b_s = '0;
`endif

  assign cur_idx_s   = cur_ch_r[IDX_W-1:0];
  assign sel_valid_s = ({1'b0, sel_i} < CH_LIMIT);
  assign vs_edge_s   = (vs_i[cur_idx_s] == VS_POL) && (vs_dly_r[cur_idx_s] != VS_POL);
  assign tmo_hit_s   = (tmo_cnt_r == TMO_LAST);

  // Request capture, select-error pulse and vsync history for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_ch_r  <= '0;
      sel_err_o <= 1'b0;
      vs_dly_r  <= {CH_CNT{VS_INACT}};
    end else begin
      if (sel_valid_s) begin
        req_ch_r <= sel_i;
      end
      sel_err_o <= ~sel_valid_s;
      vs_dly_r  <= vs_i;
    end
  end

  // Switch FSM state and counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_LOCK;
      cur_ch_r    <= '0;
      frame_cnt_r <= '0;
      tmo_cnt_r   <= '0;
    end else begin
      state_r     <= state_nxt_s;
      cur_ch_r    <= cur_ch_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      tmo_cnt_r   <= tmo_cnt_nxt_s;
    end
  end

  // Next-state logic; a timeout in WAIT_VS is treated exactly like a vs edge
  always_comb begin
    state_nxt_s     = state_r;
    cur_ch_nxt_s    = cur_ch_r;
    frame_cnt_nxt_s = frame_cnt_r;
    tmo_cnt_nxt_s   = '0;
    case (state_r)
      ST_LOCK: begin
        if (req_ch_r != cur_ch_r) begin
          state_nxt_s = ST_WAIT_VS;
        end else begin
          state_nxt_s = ST_LOCK;
        end
      end
      ST_WAIT_VS: begin
        if (req_ch_r == cur_ch_r) begin
          state_nxt_s = ST_LOCK;
        end else if (vs_edge_s || tmo_hit_s) begin
          cur_ch_nxt_s    = req_ch_r;
          frame_cnt_nxt_s = '0;
          state_nxt_s     = (BLANK_FRAMES > 0) ? ST_BLANK : ST_LOCK;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      ST_BLANK: begin
        if (vs_edge_s) begin
          if (frame_cnt_r == FR_LAST) begin
            frame_cnt_nxt_s = '0;
            state_nxt_s     = ST_LOCK;
          end else begin
            frame_cnt_nxt_s = frame_cnt_r + FR_W'(1);
          end
        end else begin
          frame_cnt_nxt_s = frame_cnt_r;
        end
      end
      default: begin
        state_nxt_s     = ST_LOCK;
        frame_cnt_nxt_s = '0;
      end
    endcase
  end

  // Output register: syncs always follow cur_ch, colours are replaced while blanking
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hs_o     <= VS_INACT;
      vs_o     <= VS_INACT;
      red_o    <= '0;
      green_o  <= '0;
      blue_o   <= '0;
      cur_ch_o <= '0;
      busy_o   <= 1'b0;
    end else begin
      hs_o     <= hs_i[cur_idx_s];
      vs_o     <= vs_i[cur_idx_s];
      cur_ch_o <= cur_ch_r;
      busy_o   <= (state_r != ST_LOCK);
      if (state_r == ST_BLANK) begin
        red_o   <= blank_r_s;
        green_o <= blank_g_s;
        blue_o  <= blank_b_s;
      end else begin
        red_o   <= red_a[cur_idx_s];
        green_o <= green_a[cur_idx_s];
        blue_o  <= blue_a[cur_idx_s];
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_mux.sv
// Directed self-checking bench for vga_frame_mux (4 channels, 2 blank frames, 100-cycle timeout).
module tb_vga_frame_mux;

  localparam int CH_CNT  = 4;
  localparam int SEL_W   = 3;
  localparam int COLOR_W = 4;

`ifdef VGA_FRAME_MUX_BLANK_COLOR_EN
  localparam logic [3:0] BLK_R = 4'hF;
`else
  localparam logic [3:0] BLK_R = 4'h0;
`endif
  localparam logic [3:0] BLK_G = 4'h0;
  localparam logic [3:0] BLK_B = 4'h0;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [SEL_W-1:0]          sel;
  logic [CH_CNT-1:0]         hs_in, vs_in;
  logic [CH_CNT*COLOR_W-1:0] red_in, green_in, blue_in;
  logic [3*COLOR_W-1:0]      blank_color;
  logic                      hs_out, vs_out, busy, sel_err;
  logic [COLOR_W-1:0]        red_out, green_out, blue_out;
  logic [SEL_W-1:0]          cur_ch;

  int checks = 0;
  int errors = 0;

  vga_frame_mux #(
    .CH_CNT(CH_CNT), .SEL_W(SEL_W), .COLOR_W(COLOR_W), .VS_POL(1'b0),
    .BLANK_FRAMES(2), .TIMEOUT_CYC(100), .TMO_W(7)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sel_i(sel), .hs_i(hs_in), .vs_i(vs_in),
    .red_i(red_in), .green_i(green_in), .blue_i(blue_in), .blank_color_i(blank_color),
    .hs_o(hs_out), .vs_o(vs_out), .red_o(red_out), .green_o(green_out), .blue_o(blue_out),
    .cur_ch_o(cur_ch), .busy_o(busy), .sel_err_o(sel_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    sel         = 3'd0;
    hs_in       = 4'hF;
    vs_in       = 4'hF;
    red_in      = 16'h4321;
    green_in    = 16'h8765;
    blue_in     = 16'hCBA9;
    blank_color = 12'hF00;
    repeat (3) tick();

    chk("rst_red", 32'(red_out), 32'h0);
    chk("rst_green", 32'(green_out), 32'h0);
    chk("rst_blue", 32'(blue_out), 32'h0);
    chk("rst_vs", 32'(vs_out), 32'h1);
    chk("rst_hs", 32'(hs_out), 32'h1);
    chk("rst_cur", 32'(cur_ch), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_selerr", 32'(sel_err), 32'h0);

    rst_n = 1'b1;
    tick();
    chk("ch0_red", 32'(red_out), 32'h1);
    chk("ch0_green", 32'(green_out), 32'h5);
    chk("ch0_blue", 32'(blue_out), 32'h9);
    red_in[3:0] = 4'hE;
    hs_in[0]    = 1'b0;
    tick();
    chk("lat_red", 32'(red_out), 32'hE);
    chk("lat_hs", 32'(hs_out), 32'h0);
    red_in[3:0] = 4'h1;
    hs_in       = 4'hF;
    tick();

    // switch 0 -> 2 mid-frame
    sel = 3'd2;
    repeat (3) tick();
    chk("wait_busy", 32'(busy), 32'h1);
    chk("wait_cur", 32'(cur_ch), 32'h0);
    chk("wait_red_old", 32'(red_out), 32'h1);
    vs_in[2] = 1'b0;
    tick();
    chk("wait_ignores_ch2_vs", 32'(vs_out), 32'h1);
    vs_in = 4'hF;
    tick();
    chk("wait_cur_hold", 32'(cur_ch), 32'h0);
    vs_in[0] = 1'b0;
    tick();
    chk("edge_vs_old", 32'(vs_out), 32'h0);
    chk("edge_red_old", 32'(red_out), 32'h1);
    vs_in = 4'hF;
    tick();
    chk("blank_cur", 32'(cur_ch), 32'h2);
    chk("blank_red", 32'(red_out), 32'(BLK_R));
    chk("blank_green", 32'(green_out), 32'(BLK_G));
    chk("blank_blue", 32'(blue_out), 32'(BLK_B));
    chk("blank_busy", 32'(busy), 32'h1);
    hs_in[2] = 1'b0;
    tick();
    chk("blank_hs_new", 32'(hs_out), 32'h0);
    hs_in    = 4'hF;
    vs_in[2] = 1'b0;
    tick();
    chk("blank_vs_new", 32'(vs_out), 32'h0);
    vs_in = 4'hF;
    repeat (2) tick();
    chk("blank_f1_busy", 32'(busy), 32'h1);
    chk("blank_f1_red", 32'(red_out), 32'(BLK_R));
    vs_in[2] = 1'b0;
    tick();
    chk("blank_f2_red", 32'(red_out), 32'(BLK_R));
    chk("blank_f2_busy", 32'(busy), 32'h1);
    vs_in = 4'hF;
    tick();
    chk("resume_red", 32'(red_out), 32'h3);
    chk("resume_green", 32'(green_out), 32'h7);
    chk("resume_busy", 32'(busy), 32'h0);
    chk("resume_cur", 32'(cur_ch), 32'h2);

    // request withdrawn before the vs edge
    sel = 3'd1;
    repeat (3) tick();
    chk("cancel_busy_up", 32'(busy), 32'h1);
    sel = 3'd2;
    repeat (2) tick();
    chk("cancel_busy_hold", 32'(busy), 32'h1);
    tick();
    chk("cancel_busy_down", 32'(busy), 32'h0);
    chk("cancel_cur", 32'(cur_ch), 32'h2);
    vs_in[2] = 1'b0;
    tick();
    vs_in = 4'hF;
    repeat (2) tick();
    chk("cancel_no_switch_cur", 32'(cur_ch), 32'h2);
    chk("cancel_no_switch_busy", 32'(busy), 32'h0);
    chk("cancel_no_switch_red", 32'(red_out), 32'h3);

    // out-of-range select
    sel = 3'd5;
    tick();
    chk("selerr_pulse", 32'(sel_err), 32'h1);
    sel = 3'd2;
    tick();
    chk("selerr_clear", 32'(sel_err), 32'h0);
    tick();
    chk("selerr_busy", 32'(busy), 32'h0);
    chk("selerr_cur", 32'(cur_ch), 32'h2);

    // dead source: ch2 vs never arrives, switch forced after 100 WAIT_VS cycles
    sel = 3'd3;
    repeat (102) tick();
    chk("tmo_before_cur", 32'(cur_ch), 32'h2);
    chk("tmo_before_busy", 32'(busy), 32'h1);
    chk("tmo_before_red", 32'(red_out), 32'h3);
    tick();
    chk("tmo_cur", 32'(cur_ch), 32'h3);
    chk("tmo_blank_red", 32'(red_out), 32'(BLK_R));
    vs_in[3] = 1'b0;
    tick();
    vs_in = 4'hF;
    tick();
    vs_in[3] = 1'b0;
    tick();
    vs_in = 4'hF;
    tick();
    chk("ch3_red", 32'(red_out), 32'h4);
    chk("ch3_green", 32'(green_out), 32'h8);
    chk("ch3_blue", 32'(blue_out), 32'hC);
    chk("ch3_busy", 32'(busy), 32'h0);

    // reset during a pending switch
    sel = 3'd0;
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #2;
    chk("midrst_cur", 32'(cur_ch), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_red", 32'(red_out), 32'h0);
    chk("midrst_vs", 32'(vs_out), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_red", 32'(red_out), 32'h1);
    chk("post_rst_cur", 32'(cur_ch), 32'h0);
    tick();
    chk("post_rst_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
